// File: rtl/uart_rx_fifo_ctrl.sv
// UART RX FIFO sequencer: one-byte skid capture, round-robin single-op FIFO access,
// local occupancy tracking, overrun drop counting and a prefetching valid/ack host port.
module uart_rx_fifo_ctrl #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned LEVEL_W = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  output logic               o_fifo_wr_req,
  output logic               o_fifo_rd_req,
  output logic [7:0]         o_fifo_wdata,
  input  logic [7:0]         i_fifo_rdata,
  input  logic               i_fifo_full,
  output logic [7:0]         o_rd_data,
  output logic               o_rd_valid,
  input  logic               i_rd_ack,
  output logic [LEVEL_W-1:0] o_level,
  output logic               o_overrun,
  output logic [CNT_W-1:0]   o_drop_count
);

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrWait,
    StRdReq,
    StRdWait,
    StRdCap
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         skid_q, skid_d;
  logic               skid_full_q, skid_full_d;
  logic [7:0]         wdata_q, wdata_d;
  logic [7:0]         rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               overrun_q, overrun_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic               last_wr_q, last_wr_d;

  logic wr_ok, rd_ok, skid_free;

  always_comb begin
    state_d     = state_q;
    skid_d      = skid_q;
    skid_full_d = skid_full_q;
    wdata_d     = wdata_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_valid_q;
    level_d     = level_q;
    overrun_d   = overrun_q;
    drop_cnt_d  = drop_cnt_q;
    last_wr_d   = last_wr_q;

    wr_ok = skid_full_q && (level_q < LEVEL_W'(DEPTH)) && !i_fifo_full;
    rd_ok = (level_q != '0) && (!rd_valid_q || i_rd_ack);

    unique case (state_q)
      StIdle: begin
        // Write wins when it is the only candidate or when the read side went last.
        if (wr_ok && (!rd_ok || !last_wr_q)) begin
          state_d   = StWrReq;
          wdata_d   = skid_q;
          last_wr_d = 1'b1;
        end else if (rd_ok) begin
          state_d   = StRdReq;
          last_wr_d = 1'b0;
        end
      end
      StWrReq: begin
        state_d = StWrWait;
        level_d = level_q + LEVEL_W'(1);
      end
      StWrWait: state_d = StIdle;
      StRdReq: begin
        state_d = StRdWait;
        level_d = level_q - LEVEL_W'(1);
      end
      StRdWait: state_d = StRdCap;
      StRdCap:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // The skid byte has already been copied into wdata_q, so it can be refilled during WR_REQ.
    skid_free = !skid_full_q || (state_q == StWrReq);
    if (state_q == StWrReq) begin
      skid_full_d = 1'b0;
    end
    if (i_rx_valid) begin
      if (skid_free) begin
        skid_d      = i_rx_data;
        skid_full_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
        if (drop_cnt_q != '1) begin
          drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
      end
    end

    if (state_q == StRdCap) begin
      rd_data_d  = i_fifo_rdata;
      rd_valid_d = 1'b1;
    end else if (rd_valid_q && i_rd_ack) begin
      rd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      skid_q      <= '0;
      skid_full_q <= 1'b0;
      wdata_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      level_q     <= '0;
      overrun_q   <= 1'b0;
      drop_cnt_q  <= '0;
      last_wr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      skid_q      <= skid_d;
      skid_full_q <= skid_full_d;
      wdata_q     <= wdata_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      level_q     <= level_d;
      overrun_q   <= overrun_d;
      drop_cnt_q  <= drop_cnt_d;
      last_wr_q   <= last_wr_d;
    end
  end

  assign o_fifo_wr_req = (state_q == StWrReq);
  assign o_fifo_rd_req = (state_q == StRdReq);
  assign o_fifo_wdata  = wdata_q;
  assign o_rd_data     = rd_data_q;
  assign o_rd_valid    = rd_valid_q;
  assign o_level       = level_q;
  assign o_overrun     = overrun_q;
  assign o_drop_count  = drop_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Bench for uart_rx_fifo_ctrl: directed protocol steps plus random traffic scored against
// an in-order byte stream model, a queue-based FIFO and a drop tally.
module tb_uart_rx_fifo_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] i_rx_data;
  logic       i_rx_valid;
  logic       o_fifo_wr_req;
  logic       o_fifo_rd_req;
  logic [7:0] o_fifo_wdata;
  logic [7:0] i_fifo_rdata;
  logic       i_fifo_full;
  logic [7:0] o_rd_data;
  logic       o_rd_valid;
  logic       i_rd_ack;
  logic [3:0] o_level;
  logic       o_overrun;
  logic [7:0] o_drop_count;

  always #5 clock = ~clock;

  uart_rx_fifo_ctrl #(
    .DEPTH  (8),
    .LEVEL_W(4),
    .CNT_W  (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_fifo_wr_req(o_fifo_wr_req),
    .o_fifo_rd_req(o_fifo_rd_req),
    .o_fifo_wdata (o_fifo_wdata),
    .i_fifo_rdata (i_fifo_rdata),
    .i_fifo_full  (i_fifo_full),
    .o_rd_data    (o_rd_data),
    .o_rd_valid   (o_rd_valid),
    .i_rd_ack     (i_rd_ack),
    .o_level      (o_level),
    .o_overrun    (o_overrun),
    .o_drop_count (o_drop_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: external FIFO contents, accepted bytes in arrival order, skid, drops.
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] skid_b;
  bit         skid_occ;
  int         drops;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic       wr, rd;
    logic [7:0] rbyte;
    wr = 1'b0;
    rd = 1'b0;
    rbyte = 8'h00;
    if (!reset) begin
      wr = o_fifo_wr_req;
      rd = o_fifo_rd_req;
      check("one_req_at_a_time", 32'(wr & rd), 32'd0);
      if (i_rd_ack && o_rd_valid) begin
        check("host_not_underflow", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("host_byte", 32'(o_rd_data), 32'(exp_q.pop_front()));
      end
      if (wr) begin
        check("wr_has_skid", 32'(skid_occ), 32'd1);
        check("wdata", 32'(o_fifo_wdata), 32'(skid_b));
        fifo_q.push_back(o_fifo_wdata);
        check("fifo_bound", 32'(fifo_q.size() <= 8), 32'd1);
        skid_occ = 1'b0;
      end
      if (rd) begin
        check("rd_not_empty", 32'(fifo_q.size() != 0), 32'd1);
        if (fifo_q.size() != 0) rbyte = fifo_q.pop_front();
      end
      if (i_rx_valid) begin
        if (skid_occ) begin
          drops++;
        end else begin
          skid_occ = 1'b1;
          skid_b   = i_rx_data;
          exp_q.push_back(i_rx_data);
        end
      end
    end
    @(posedge clock);
    #1;
    if (rd) i_fifo_rdata = rbyte;
    if (reset) begin
      fifo_q.delete();
      exp_q.delete();
      skid_occ = 1'b0;
      drops    = 0;
    end
    check("level", 32'(o_level), 32'(fifo_q.size()));
    check("drop_count", 32'(o_drop_count), 32'((drops > 255) ? 255 : drops));
    check("overrun", 32'(o_overrun), 32'(drops != 0));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_wr_req", 32'(o_fifo_wr_req), 32'd0);
    check("rst_rd_req", 32'(o_fifo_rd_req), 32'd0);
    check("rst_wdata", 32'(o_fifo_wdata), 32'd0);
    check("rst_rd_data", 32'(o_rd_data), 32'd0);
    check("rst_rd_valid", 32'(o_rd_valid), 32'd0);
    check("rst_level", 32'(o_level), 32'd0);
  endtask

  task automatic wait_rd_req();
    int n = 0;
    while (o_fifo_rd_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("rd_req_seen", 32'(o_fifo_rd_req), 32'd1);
  endtask

  initial begin
    reset        = 1'b0;
    i_rx_data    = 8'h00;
    i_rx_valid   = 1'b0;
    i_fifo_rdata = 8'h00;
    i_fifo_full  = 1'b0;
    i_rd_ack     = 1'b0;
    skid_occ     = 1'b0;
    skid_b       = 8'h00;
    drops        = 0;

    // Single byte latency: write 2 cycles after the strobe, read, data 3 cycles after RD_REQ.
    do_reset();
    send(8'h41);
    check("t1_wr_early", 32'(o_fifo_wr_req), 32'd0);
    tick();
    check("t1_wr_req", 32'(o_fifo_wr_req), 32'd1);
    tick();
    check("t1_wr_pulse", 32'(o_fifo_wr_req), 32'd0);
    check("t1_wait_wdata", 32'(o_fifo_wdata), 32'h41);
    tick();
    tick();
    check("t1_rd_req", 32'(o_fifo_rd_req), 32'd1);
    tick();
    check("t1_rd_pulse", 32'(o_fifo_rd_req), 32'd0);
    tick();
    check("t1_valid_early", 32'(o_rd_valid), 32'd0);
    tick();
    check("t1_valid", 32'(o_rd_valid), 32'd1);
    check("t1_data", 32'(o_rd_data), 32'h41);

    // Fill without acks: 0x00 prefetched, 0x01..0x08 in FIFO, 0x09 parked in skid.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      send(8'(i));
      ticks(5);
    end
    ticks(6);
    check("t2_level_full", 32'(o_level), 32'd8);
    check("t2_prefetch_valid", 32'(o_rd_valid), 32'd1);
    check("t2_prefetch_data", 32'(o_rd_data), 32'h00);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t2_no_wr_at_full", 32'(o_fifo_wr_req), 32'd0);
    end

    // Overflow drop, then ack frees a FIFO slot so the parked skid byte goes in.
    send(8'hAA);
    check("t3_drop_count", 32'(o_drop_count), 32'd1);
    check("t3_overrun", 32'(o_overrun), 32'd1);
    i_rd_ack = 1'b1;
    tick();
    i_rd_ack = 1'b0;
    ticks(8);
    check("t3_next_valid", 32'(o_rd_valid), 32'd1);
    check("t3_next_data", 32'(o_rd_data), 32'h01);
    check("t3_level_refill", 32'(o_level), 32'd8);

    // Both sides eligible in IDLE after a write grant: read goes first.
    do_reset();
    send(8'h11);
    ticks(8);
    check("t4_a_valid", 32'(o_rd_valid), 32'd1);
    send(8'h22);
    ticks(4);
    send(8'h33);
    i_rd_ack = 1'b1;
    tick();
    i_rd_ack = 1'b0;
    check("t4_rd_first", 32'(o_fifo_rd_req), 32'd1);
    check("t4_no_wr_first", 32'(o_fifo_wr_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_wr_held", 32'(o_fifo_wr_req), 32'd0);
    end
    tick();
    check("t4_wr_second", 32'(o_fifo_wr_req), 32'd1);
    check("t4_b_data", 32'(o_rd_data), 32'h22);

    // Reset mid-operation in WR_WAIT and in RD_WAIT.
    do_reset();
    send(8'h5A);
    tick();
    tick();
    check("t5_in_wr_wait", 32'(o_level), 32'd1);
    do_reset();
    tick();
    check("t5_idle_after_wr", 32'(o_fifo_wr_req | o_fifo_rd_req), 32'd0);
    send(8'hC3);
    wait_rd_req();
    tick();
    do_reset();
    ticks(4);
    check("t5_no_capture", 32'(o_rd_valid), 32'd0);

    // Randomized traffic against the model, then drain.
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      i_rx_valid  = ($urandom_range(0, 99) < 35);
      i_rx_data   = 8'($urandom);
      i_rd_ack    = 1'($urandom);
      i_fifo_full = ($urandom_range(0, 9) == 0);
      tick();
    end
    i_rx_valid  = 1'b0;
    i_fifo_full = 1'b0;
    i_rd_ack    = 1'b1;
    for (int n = 0; n < 300 && (exp_q.size() != 0 || o_rd_valid); n++) tick();
    i_rd_ack = 1'b0;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_valid", 32'(o_rd_valid), 32'd0);

    // Drop counter saturation with writes inhibited by i_fifo_full.
    do_reset();
    i_fifo_full = 1'b1;
    send(8'h55);
    i_rx_valid = 1'b1;
    for (int i = 0; i < 260; i++) begin
      i_rx_data = 8'(i);
      tick();
      check("t6_no_wr_when_full", 32'(o_fifo_wr_req), 32'd0);
    end
    i_rx_valid = 1'b0;
    check("t6_saturated", 32'(o_drop_count), 32'hFF);
    i_fifo_full = 1'b0;
    i_rd_ack    = 1'b1;
    ticks(12);
    i_rd_ack = 1'b0;
    check("t6_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
